// File: rtl/vic_arbiter_if.sv
// Bus bundle between IRQ sources, the vectored interrupt arbiter and the CPU interrupt entry logic.
interface vic_arbiter_if #(
  parameter int NUM_IRQ = 16,
  parameter int IDX_W   = 4
);
  logic [NUM_IRQ-1:0] irq_src;
  logic               nv_irq;
  logic [NUM_IRQ-1:0] irq_enable;
  logic [NUM_IRQ-1:0] irq_edge_mode;
  logic               ack;
  logic               eoi;
  logic               irq_req;
  logic [IDX_W-1:0]   handler_num;
  logic               is_nv;
  logic               in_service;
  logic [NUM_IRQ-1:0] pending;

  modport slave (
    input  irq_src, nv_irq, irq_enable, irq_edge_mode, ack, eoi,
    output irq_req, handler_num, is_nv, in_service, pending
  );

  modport master (
    output irq_src, nv_irq, irq_enable, irq_edge_mode, ack, eoi,
    input  irq_req, handler_num, is_nv, in_service, pending
  );
endinterface

// File: rtl/vic_arbiter.sv
// Vectored interrupt arbiter: pending latches, fixed priority (NMI first, then lowest index),
// and a registered request / ack / end-of-interrupt handshake with in-service tracking.
module vic_arbiter #(
  parameter int NUM_IRQ = 16,
  parameter int IDX_W   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  vic_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} ArbState;

  ArbState            state;
  logic [NUM_IRQ-1:0] history;
  logic [NUM_IRQ-1:0] cand;
  logic [NUM_IRQ-1:0] edgeSeen;
  logic [NUM_IRQ-1:0] ackClear;
  logic [NUM_IRQ-1:0] pendingNext;
  logic [IDX_W-1:0]   winner;
  logic               anyReq;
  logic               ackTaken;

  // Descending scan so the lowest enabled pending index is the last assignment.
  always_comb begin
    cand     = bus.pending & bus.irq_enable;
    anyReq   = bus.nv_irq | (|cand);
    ackTaken = (state == REQ) && bus.ack;
    edgeSeen = bus.irq_src & ~history;
    winner   = '0;
    ackClear = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (cand[i]) winner = IDX_W'(i);
      ackClear[i] = ackTaken && !bus.is_nv && (bus.handler_num == IDX_W'(i));
    end
    // A fresh edge outranks the ack clear so a back-to-back event is never lost.
    pendingNext = (bus.irq_edge_mode & (edgeSeen | (bus.pending & ~ackClear)))
                | (~bus.irq_edge_mode & bus.irq_src);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      history         <= '0;
      bus.pending     <= '0;
      bus.irq_req     <= 1'b0;
      bus.handler_num <= '0;
      bus.is_nv       <= 1'b0;
      bus.in_service  <= 1'b0;
    end else begin
      history     <= bus.irq_src;
      bus.pending <= pendingNext;
      case (state)
        IDLE: begin
          if (anyReq) begin
            state           <= REQ;
            bus.irq_req     <= 1'b1;
            bus.is_nv       <= bus.nv_irq;
            bus.handler_num <= bus.nv_irq ? '0 : winner;
          end
        end
        REQ: begin
          if (bus.ack) begin
            state          <= SERVICE;
            bus.irq_req    <= 1'b0;
            bus.in_service <= 1'b1;
          end else if (!anyReq) begin
            state       <= IDLE;
            bus.irq_req <= 1'b0;
            bus.is_nv   <= 1'b0;
          end else begin
            bus.is_nv       <= bus.nv_irq;
            bus.handler_num <= bus.nv_irq ? '0 : winner;
          end
        end
        SERVICE: begin
          // No nesting: new events wait in pending until the handler finishes.
          if (bus.eoi) begin
            state          <= IDLE;
            bus.in_service <= 1'b0;
            bus.is_nv      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vic_arbiter.sv
// Self-checking bench for vic_arbiter: directed vector table, async reset sequence,
// then randomized traffic compared against a behavioural reference model.
module tb_vic_arbiter;

  localparam int N = 16;
  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  vic_arbiter_if #(.NUM_IRQ(N), .IDX_W(W)) bus ();

  vic_arbiter #(.NUM_IRQ(N), .IDX_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] src;
    logic         nv;
    logic [N-1:0] en;
    logic [N-1:0] edgeMode;
    logic         ack;
    logic         eoi;
    logic         expReq;
    logic [W-1:0] expHandler;
    logic         expNv;
    logic         expServ;
    logic [N-1:0] expPending;
  } TableVec;

  TableVec vecs[$];

  // Reference model state: request outstanding, handler running, and what was offered.
  logic [N-1:0] mPend;
  logic [N-1:0] mHist;
  logic         mReq;
  logic         mServ;
  logic         mNv;
  int           mHandler;

  function automatic TableVec mkVec(logic [N-1:0] src, logic nv, logic [N-1:0] en,
                                    logic [N-1:0] edgeMode, logic ack, logic eoi,
                                    logic expReq, int expHandler, logic expNv,
                                    logic expServ, logic [N-1:0] expPending);
    TableVec v;
    v.src = src; v.nv = nv; v.en = en; v.edgeMode = edgeMode; v.ack = ack; v.eoi = eoi;
    v.expReq = expReq; v.expHandler = W'(expHandler); v.expNv = expNv;
    v.expServ = expServ; v.expPending = expPending;
    return v;
  endfunction

  task automatic modelReset();
    mPend = '0; mHist = '0; mReq = 1'b0; mServ = 1'b0; mNv = 1'b0; mHandler = 0;
  endtask

  task automatic modelStep();
    logic [N-1:0] cand;
    logic [N-1:0] nextPend;
    int           win;
    logic         anyReq;
    logic         ackTaken;
    cand = mPend & bus.irq_enable;
    win = -1;
    for (int i = 0; i < N; i++) if (cand[i] && win < 0) win = i;
    anyReq   = bus.nv_irq || (win >= 0);
    ackTaken = bus.ack && mReq;
    for (int i = 0; i < N; i++) begin
      if (!bus.irq_edge_mode[i])               nextPend[i] = bus.irq_src[i];
      else if (bus.irq_src[i] && !mHist[i])    nextPend[i] = 1'b1;
      else if (ackTaken && !mNv && mHandler == i) nextPend[i] = 1'b0;
      else                                     nextPend[i] = mPend[i];
    end
    if (mReq) begin
      if (ackTaken) begin
        mReq = 1'b0; mServ = 1'b1;
      end else if (!anyReq) begin
        mReq = 1'b0; mNv = 1'b0;
      end else begin
        mNv = bus.nv_irq; mHandler = bus.nv_irq ? 0 : win;
      end
    end else if (mServ) begin
      if (bus.eoi) begin
        mServ = 1'b0; mNv = 1'b0;
      end
    end else if (anyReq) begin
      mReq = 1'b1; mNv = bus.nv_irq; mHandler = bus.nv_irq ? 0 : win;
    end
    mHist = bus.irq_src;
    mPend = nextPend;
  endtask

  task automatic applyStimulus(input logic [N-1:0] src, input logic nv, input logic [N-1:0] en,
                               input logic [N-1:0] edgeMode, input logic ack, input logic eoi);
    bus.irq_src       = src;
    bus.nv_irq        = nv;
    bus.irq_enable    = en;
    bus.irq_edge_mode = edgeMode;
    bus.ack           = ack;
    bus.eoi           = eoi;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  // handler_num / is_nv only carry meaning while a request or service is active, unless strict.
  task automatic checkOutput(input string name, input logic strict, input logic expReq,
                             input logic [W-1:0] expHandler, input logic expNv,
                             input logic expServ, input logic [N-1:0] expPending);
    logic ok;
    vectors++;
    ok = (bus.irq_req === expReq) && (bus.in_service === expServ) && (bus.pending === expPending);
    if (strict || expReq || expServ)
      ok = ok && (bus.handler_num === expHandler) && (bus.is_nv === expNv);
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL %s @%0t: got req=%b hn=%0d nv=%b svc=%b pend=%h, expected req=%b hn=%0d nv=%b svc=%b pend=%h",
               name, $time, bus.irq_req, bus.handler_num, bus.is_nv, bus.in_service, bus.pending,
               expReq, expHandler, expNv, expServ, expPending);
    end
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, 1'b0, mReq, W'(mHandler), mNv, mServ, mPend);
  endtask

  task automatic asyncReset();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset", 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    modelReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] rSrc;
    logic [N-1:0] rEn;
    logic [N-1:0] rEdge;

    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus.irq_src = '0; bus.nv_irq = 1'b0; bus.irq_enable = '1; bus.irq_edge_mode = '1;
    bus.ack = 1'b0; bus.eoi = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset values", 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    rst_n = 1'b1;

    // src, nv, en, edgeMode, ack, eoi -> req, handler, isNv, inService, pending
    vecs.push_back(mkVec(16'h0000, 0, 16'hffff, 16'hffff, 0, 0, 0, 0, 0, 0, 16'h0000));
    vecs.push_back(mkVec(16'h0100, 0, 16'hffff, 16'hffff, 0, 0, 0, 0, 0, 0, 16'h0100));
    vecs.push_back(mkVec(16'h0000, 0, 16'hffff, 16'hffff, 0, 0, 1, 8, 0, 0, 16'h0100));
    vecs.push_back(mkVec(16'h0000, 0, 16'hffff, 16'hffff, 1, 0, 0, 8, 0, 1, 16'h0000));
    vecs.push_back(mkVec(16'h0000, 0, 16'hffff, 16'hffff, 0, 1, 0, 0, 0, 0, 16'h0000));
    vecs.push_back(mkVec(16'h0f00, 0, 16'hffff, 16'hffff, 0, 0, 0, 0, 0, 0, 16'h0f00));
    vecs.push_back(mkVec(16'h0f00, 0, 16'hffff, 16'hffff, 0, 0, 1, 8, 0, 0, 16'h0f00));
    vecs.push_back(mkVec(16'h0f00, 0, 16'hffff, 16'hffff, 1, 0, 0, 8, 0, 1, 16'h0e00));
    vecs.push_back(mkVec(16'h0f00, 0, 16'hffff, 16'hffff, 0, 1, 0, 0, 0, 0, 16'h0e00));
    vecs.push_back(mkVec(16'h0f00, 0, 16'hffff, 16'hffff, 0, 0, 1, 9, 0, 0, 16'h0e00));
    vecs.push_back(mkVec(16'h0f00, 0, 16'hffff, 16'hffff, 1, 0, 0, 9, 0, 1, 16'h0c00));
    vecs.push_back(mkVec(16'h0f00, 0, 16'hffff, 16'hffff, 0, 1, 0, 0, 0, 0, 16'h0c00));
    vecs.push_back(mkVec(16'h0f00, 0, 16'hffff, 16'hffff, 0, 0, 1, 10, 0, 0, 16'h0c00));
    vecs.push_back(mkVec(16'h0f00, 0, 16'hffff, 16'hffff, 1, 0, 0, 10, 0, 1, 16'h0800));
    vecs.push_back(mkVec(16'h0f00, 0, 16'hffff, 16'hffff, 0, 1, 0, 0, 0, 0, 16'h0800));
    vecs.push_back(mkVec(16'h0f00, 0, 16'hffff, 16'hffff, 0, 0, 1, 11, 0, 0, 16'h0800));
    vecs.push_back(mkVec(16'h0f00, 0, 16'hffff, 16'hffff, 1, 0, 0, 11, 0, 1, 16'h0000));
    vecs.push_back(mkVec(16'h0f00, 0, 16'hffff, 16'hffff, 0, 1, 0, 0, 0, 0, 16'h0000));
    vecs.push_back(mkVec(16'h0000, 0, 16'hffff, 16'hffff, 0, 0, 0, 0, 0, 0, 16'h0000));
    vecs.push_back(mkVec(16'h0100, 0, 16'hffff, 16'hffff, 0, 0, 0, 0, 0, 0, 16'h0100));
    vecs.push_back(mkVec(16'h0100, 0, 16'hffff, 16'hffff, 0, 0, 1, 8, 0, 0, 16'h0100));
    vecs.push_back(mkVec(16'h0100, 1, 16'hffff, 16'hffff, 0, 0, 1, 0, 1, 0, 16'h0100));
    vecs.push_back(mkVec(16'h0100, 1, 16'hffff, 16'hffff, 1, 0, 0, 0, 1, 1, 16'h0100));
    vecs.push_back(mkVec(16'h0100, 0, 16'hffff, 16'hffff, 0, 1, 0, 0, 0, 0, 16'h0100));
    vecs.push_back(mkVec(16'h0100, 0, 16'hffff, 16'hffff, 0, 0, 1, 8, 0, 0, 16'h0100));
    vecs.push_back(mkVec(16'h0100, 0, 16'hffff, 16'hffff, 1, 0, 0, 8, 0, 1, 16'h0000));
    vecs.push_back(mkVec(16'h0000, 0, 16'hffff, 16'hffff, 0, 1, 0, 0, 0, 0, 16'h0000));
    vecs.push_back(mkVec(16'hffff, 0, 16'h0000, 16'hffff, 0, 0, 0, 0, 0, 0, 16'hffff));
    vecs.push_back(mkVec(16'hffff, 0, 16'h0000, 16'hffff, 0, 0, 0, 0, 0, 0, 16'hffff));
    vecs.push_back(mkVec(16'hffff, 0, 16'h0004, 16'hffff, 0, 0, 1, 2, 0, 0, 16'hffff));
    vecs.push_back(mkVec(16'hffff, 0, 16'h0004, 16'hffff, 1, 0, 0, 2, 0, 1, 16'hfffb));
    vecs.push_back(mkVec(16'hffff, 0, 16'h0004, 16'hffff, 0, 1, 0, 0, 0, 0, 16'hfffb));
    vecs.push_back(mkVec(16'hffff, 0, 16'h0004, 16'hffff, 0, 0, 0, 0, 0, 0, 16'hfffb));
    vecs.push_back(mkVec(16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000));
    vecs.push_back(mkVec(16'h0008, 0, 16'hffff, 16'hfff7, 0, 0, 0, 0, 0, 0, 16'h0008));
    vecs.push_back(mkVec(16'h0008, 0, 16'hffff, 16'hfff7, 0, 0, 1, 3, 0, 0, 16'h0008));
    vecs.push_back(mkVec(16'h0000, 0, 16'hffff, 16'hfff7, 0, 0, 1, 3, 0, 0, 16'h0000));
    vecs.push_back(mkVec(16'h0000, 0, 16'hffff, 16'hfff7, 0, 0, 0, 0, 0, 0, 16'h0000));
    vecs.push_back(mkVec(16'h0008, 0, 16'hffff, 16'hffff, 0, 0, 0, 0, 0, 0, 16'h0008));
    vecs.push_back(mkVec(16'h0000, 0, 16'hffff, 16'hffff, 0, 0, 1, 3, 0, 0, 16'h0008));
    vecs.push_back(mkVec(16'h0008, 0, 16'hffff, 16'hffff, 1, 0, 0, 3, 0, 1, 16'h0008));
    vecs.push_back(mkVec(16'h0008, 0, 16'hffff, 16'hffff, 0, 1, 0, 0, 0, 0, 16'h0008));
    vecs.push_back(mkVec(16'h0008, 0, 16'hffff, 16'hffff, 0, 0, 1, 3, 0, 0, 16'h0008));
    vecs.push_back(mkVec(16'h0008, 0, 16'hffff, 16'hffff, 1, 0, 0, 3, 0, 1, 16'h0000));
    vecs.push_back(mkVec(16'h0008, 0, 16'hffff, 16'hffff, 0, 1, 0, 0, 0, 0, 16'h0000));
    vecs.push_back(mkVec(16'h0008, 0, 16'hffff, 16'hffff, 1, 1, 0, 0, 0, 0, 16'h0000));
    vecs.push_back(mkVec(16'h0008, 0, 16'hffff, 16'hffff, 0, 1, 0, 0, 0, 0, 16'h0000));

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].src, vecs[k].nv, vecs[k].en, vecs[k].edgeMode, vecs[k].ack, vecs[k].eoi);
      checkOutput($sformatf("table[%0d]", k), 1'b0, vecs[k].expReq, vecs[k].expHandler,
                  vecs[k].expNv, vecs[k].expServ, vecs[k].expPending);
      checkModel($sformatf("table model[%0d]", k));
    end

    // Reach SERVICE on source 5, then pull reset between clock edges.
    applyStimulus(16'h0020, 1'b0, 16'hffff, 16'hffff, 1'b0, 1'b0);
    applyStimulus(16'h0020, 1'b0, 16'hffff, 16'hffff, 1'b0, 1'b0);
    checkOutput("src5 request", 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 16'h0020);
    applyStimulus(16'h0020, 1'b0, 16'hffff, 16'hffff, 1'b1, 1'b0);
    checkOutput("src5 service", 1'b0, 1'b0, 4'd5, 1'b0, 1'b1, 16'h0000);
    asyncReset();
    applyStimulus(16'h0020, 1'b0, 16'hffff, 16'hffff, 1'b0, 1'b0);
    checkOutput("edge after reset", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0020);
    applyStimulus(16'h0020, 1'b0, 16'hffff, 16'hffff, 1'b1, 1'b1);
    checkModel("post-reset ack+eoi");

    rSrc  = '0;
    rEn   = '1;
    rEdge = 16'($urandom) | 16'($urandom);
    for (int c = 0; c < 800; c++) begin
      rSrc = rSrc ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      if ($urandom_range(0, 19) == 0) rEn = 16'($urandom) | 16'($urandom);
      if ($urandom_range(0, 29) == 0) rEdge = rEdge ^ (16'd1 << $urandom_range(0, N - 1));
      if ($urandom_range(0, 149) == 0) begin
        asyncReset();
      end else begin
        applyStimulus(rSrc, ($urandom_range(0, 9) == 0), rEn, rEdge,
                      ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
        checkModel("random");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
